// File: rtl/c_pipe_issue.sv
// In-order issue stage: instruction FIFO, a shift-register scoreboard for RAW hazards,
// and registered decode outputs that carry a bubble whenever nothing issues.
module c_pipe_issue #(
    parameter int DEPTH   = 8,
    parameter int HAZ_WIN = 3
) (
    input  logic                     clk1,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [23:0]              in_instr,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [3:0]               rs1,
    output logic [3:0]               rs2,
    output logic [3:0]               rd,
    output logic [3:0]               func,
    output logic [7:0]               addr,
    output logic                     illegal,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              stall_cnt,
    output logic [15:0]              issued_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [23:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          sb_valid [HAZ_WIN];
    logic [3:0]    sb_rd    [HAZ_WIN];

    logic [23:0]   head;
    logic [3:0]    h_func;
    logic [3:0]    h_rd;
    logic [3:0]    h_rs1;
    logic [3:0]    h_rs2;
    logic [7:0]    h_addr;
    logic          use_rs1;
    logic          use_rs2;
    logic          hazard;
    logic          empty;
    logic          head_illegal;
    logic          do_issue;
    logic          do_stall;
    logic          do_pop;
    logic          do_push;

    assign in_ready = (fifo_level != FULL_LVL);
    assign empty    = (fifo_level == '0);

    assign head   = mem[rd_ptr];
    assign h_func = head[23:20];
    assign h_rd   = head[19:16];
    assign h_rs1  = head[15:12];
    assign h_rs2  = head[11:8];
    assign h_addr = head[7:0];

    always_comb begin
        use_rs1 = h_func inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd10, 4'd11};
        use_rs2 = h_func inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9};
        hazard  = 1'b0;
        for (int unsigned i = 0; i < HAZ_WIN; i++) begin
            if (sb_valid[i] && ((use_rs1 && (h_rs1 == sb_rd[i])) ||
                                (use_rs2 && (h_rs2 == sb_rd[i]))))
                hazard = 1'b1;
        end
    end

    // Flush overrides every datapath action on its edge, including the incoming push.
    assign head_illegal = !empty && (h_func > 4'd11);
    assign do_issue     = !empty && !head_illegal && !hazard && !flush;
    assign do_stall     = !empty && !head_illegal &&  hazard && !flush;
    assign do_pop       = do_issue || (head_illegal && !flush);
    assign do_push      = in_valid && in_ready && !flush;

    always_ff @(posedge clk1) begin
        if (do_push)
            mem[wr_ptr] <= in_instr;
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            for (int unsigned i = 0; i < HAZ_WIN; i++) begin
                sb_valid[i] <= 1'b0;
                sb_rd[i]    <= '0;
            end
            out_valid  <= 1'b0;
            illegal    <= 1'b0;
            func       <= '1;
            rd         <= '0;
            rs1        <= '0;
            rs2        <= '0;
            addr       <= '0;
            stall_cnt  <= '0;
            issued_cnt <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            for (int unsigned i = 0; i < HAZ_WIN; i++) begin
                sb_valid[i] <= 1'b0;
                sb_rd[i]    <= '0;
            end
            out_valid  <= 1'b0;
            illegal    <= 1'b0;
            func       <= '1;
            rd         <= '0;
            rs1        <= '0;
            rs2        <= '0;
            addr       <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase

            for (int unsigned i = 1; i < HAZ_WIN; i++) begin
                sb_valid[i] <= sb_valid[i-1];
                sb_rd[i]    <= sb_rd[i-1];
            end
            sb_valid[0] <= do_issue;
            sb_rd[0]    <= do_issue ? h_rd : '0;

            out_valid <= do_issue;
            illegal   <= head_illegal;
            if (do_issue) begin
                func <= h_func;
                rd   <= h_rd;
                rs1  <= h_rs1;
                rs2  <= h_rs2;
                addr <= h_addr;
            end else begin
                func <= '1;
                rd   <= '0;
                rs1  <= '0;
                rs2  <= '0;
                addr <= '0;
            end

            if (do_issue && (issued_cnt != '1))
                issued_cnt <= issued_cnt + 16'd1;
            if (do_stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
